// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one WIDTH/STAGES chunk per stage,
// carry registered between chunks, valid/ready on both sides.
module csa_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SEG    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int NSEG = CW / SEG;
  localparam int L    = STAGES - 1;

  if ((STAGES < 1) || (STAGES > 4) ||
      (WIDTH % (STAGES * SEG) != 0)) begin : g_bad_params
    $error("csa_pipe_adder: illegal WIDTH/STAGES/SEG");
  end

  // Returns {carry into chunk MSB, chunk carry out, chunk sum}.
  function automatic logic [CW+1:0] chunk_add(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b,
    input logic          ci
  );
    logic [CW-1:0] s;
    logic          c;
    logic [SEG:0]  s0;
    logic [SEG:0]  s1;
    s = '0;
    c = ci;
    for (int i = 0; i < NSEG; i++) begin
      s0 = {1'b0, a[i*SEG +: SEG]} + {1'b0, b[i*SEG +: SEG]};
      s1 = {1'b0, a[i*SEG +: SEG]} + {1'b0, b[i*SEG +: SEG]}
         + {{SEG{1'b0}}, 1'b1};
      s[i*SEG +: SEG] = c ? s1[SEG-1:0] : s0[SEG-1:0];
      c = c ? s1[SEG] : s0[SEG];
    end
    return {a[CW-1] ^ b[CW-1] ^ s[CW-1], c, s};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] free;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  b_q  [STAGES];
  logic [WIDTH-1:0]  r_q  [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  r_in [STAGES];
  logic [WIDTH-1:0]  r_d  [STAGES];
  logic              cm_q;
  logic              cm_d;

  always_comb begin : stage_src
    v_in[0] = in_valid;
    a_in[0] = din1;
    b_in[0] = sub ? ~din2 : din2;
    c_in[0] = sub | carry_in;
    r_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      r_in[k] = r_q[k-1];
    end
  end

  always_comb begin : datapath
    logic [CW+1:0] ch;
    ch = '0;
    for (int k = 0; k < STAGES; k++) begin
      ch = chunk_add(a_in[k][k*CW +: CW],
                     b_in[k][k*CW +: CW], c_in[k]);
      r_d[k] = r_in[k];
      r_d[k][k*CW +: CW] = ch[CW-1:0];
      c_d[k] = ch[CW];
    end
    cm_d = ch[CW+1];
  end

  // A stage may load when it or anything downstream has a free slot.
  always_comb begin : flow
    logic acc;
    acc = out_ready;
    for (int k = L; k >= 0; k--) begin
      acc = acc | ~v_q[k];
      free[k] = acc;
    end
  end

  assign in_ready = free[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      cm_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (free[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            r_q[k] <= r_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (free[L] && v_in[L]) cm_q <= cm_d;
    end
  end

  assign out_valid = v_q[L];
  assign dout      = r_q[L];
  assign carry_out = c_q[L];
  assign overflow  = cm_q ^ c_q[L];
  assign zero      = v_q[L] & ~|r_q[L];

endmodule
